keypad_scanner: RTL and testbench

- Producer end of the digit interface consumed by the lock: scans a 4x4 matrix keypad, debounces one key, and emits its 4-bit code with a one-cycle valid strobe.
- Sits between the physical keypad pins and the lock's digit inputs.
- Single clock domain; column inputs are asynchronous and synchronised internally.

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_scanner_if.sv | 11 +
 rtl/keypad_scanner_col_sync.sv | 21 ++
 rtl/keypad_scanner.sv | 110 +++++++++++
 tb/tb_keypad_scanner.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key map and column decode for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } state_e;

   localparam int SCAN_CYCLES_DEF     = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 4;

   // Indexed by {row_idx, col_idx}; entry 0 is r0c0.
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   typedef struct packed {
      logic       one;
      logic [1:0] idx;
   } col_dec_t;

   // Flags a column pattern with exactly one low bit and returns its position.
   function automatic col_dec_t col_decode(input logic [3:0] cs);
      col_dec_t r;
      r.one = 1'b0;
      r.idx = 2'd0;
      case (cs)
         4'b1110: begin r.one = 1'b1; r.idx = 2'd0; end
         4'b1101: begin r.one = 1'b1; r.idx = 2'd1; end
         4'b1011: begin r.one = 1'b1; r.idx = 2'd2; end
         4'b0111: begin r.one = 1'b1; r.idx = 2'd3; end
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the digit bus toward the lock.
interface keypad_scanner_if;
   logic [3:0] col;
   logic [3:0] row;
   logic [3:0] digit;
   logic       digit_valid;
   logic       key_held;

   modport master (input col, output row, digit, digit_valid, key_held);
   modport slave  (output col, input row, digit, digit_valid, key_held);
endinterface

// File: rtl/keypad_scanner_col_sync.sv
// Two-flop synchroniser for the asynchronous column inputs; idles at all-ones.
module col_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d_i,
   output logic [3:0] q_o
);
   logic [3:0] s1_q, s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 4'hF;
         s2_q <= 4'hF;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, single-key debounce, one-cycle digit strobe.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = SCAN_CYCLES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   keypad_scanner_if.master  kp
);
   localparam int DW = $clog2(SCAN_CYCLES);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [3:0]    cs;
   state_e        state_q;
   logic [1:0]    row_idx_q, cap_idx_q, row_nxt;
   logic [DW-1:0] dwell_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    cap_q, row_q, digit_q;
   logic          valid_q, held_q;
   col_dec_t      dec;

   col_sync u_sync (.clk(clk), .rst_n(reset), .d_i(kp.col), .q_o(cs));

   assign dec     = col_decode(cs);
   assign row_nxt = row_idx_q + 2'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= SCAN;
         row_idx_q <= 2'd0;
         cap_idx_q <= 2'd0;
         dwell_q   <= '0;
         cnt_q     <= '0;
         cap_q     <= 4'hF;
         row_q     <= 4'b1110;
         digit_q   <= 4'h0;
         valid_q   <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            SCAN: begin
               if (dwell_q == DW'(SCAN_CYCLES - 1)) begin
                  dwell_q <= '0;
                  if (dec.one) begin
                     state_q   <= DEBOUNCE;
                     cap_q     <= cs;
                     cap_idx_q <= dec.idx;
                     cnt_q     <= '0;
                  end else begin
                     // Idle, ghost or multi-key sample: move on to the next row.
                     row_idx_q <= row_nxt;
                     row_q     <= ~(4'b0001 << row_nxt);
                  end
               end else begin
                  dwell_q <= dwell_q + 1'b1;
               end
            end
            DEBOUNCE: begin
               if (cs == cap_q) begin
                  if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                     digit_q <= KEY_MAP[{row_idx_q, cap_idx_q}];
                     valid_q <= 1'b1;
                     held_q  <= 1'b1;
                     state_q <= PRESSED;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else begin
                  state_q   <= SCAN;
                  row_idx_q <= 2'd0;
                  dwell_q   <= '0;
                  row_q     <= 4'b1110;
               end
            end
            PRESSED: begin
               if (cs == 4'hF) begin
                  state_q <= RELEASE;
                  cnt_q   <= '0;
               end
            end
            RELEASE: begin
               if (cs == 4'hF) begin
                  if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                     held_q    <= 1'b0;
                     state_q   <= SCAN;
                     row_idx_q <= 2'd0;
                     dwell_q   <= '0;
                     row_q     <= 4'b1110;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else begin
                  // Release bounce re-arms PRESSED without a second strobe.
                  state_q <= PRESSED;
                  cnt_q   <= '0;
               end
            end
            default: state_q <= SCAN;
         endcase
      end
   end

   assign kp.row         = row_q;
   assign kp.digit       = digit_q;
   assign kp.digit_valid = valid_q;
   assign kp.key_held    = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix model and a cycle-level reference.
module tb_keypad_scanner;
   localparam int SC = 4;
   localparam int DB = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] keys = '0;
   int          checks = 0;
   int          failures = 0;
   int          pulses = 0;
   logic        prev_valid = 1'b0;

   keypad_scanner_if kif ();

   keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .kp(kif.master)
   );

   always #5 clk = ~clk;

   // Passive matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      kif.col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !kif.row[r]) kif.col[c] = 1'b0;
   end

   logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                             4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC,
                             4'hE, 4'h0, 4'hF, 4'hD};

   // Reference: scan position is elapsed time since the scan restarted.
   logic [3:0] m_s1, m_cs, m_row, m_digit, m_cap, m_code;
   logic       m_valid, m_held;
   int         m_mode, m_scan_t, m_run;

   task automatic model_reset();
      m_s1 = 4'hF; m_cs = 4'hF; m_row = 4'b1110; m_digit = 4'h0; m_cap = 4'hF;
      m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0; m_mode = 0; m_scan_t = 0; m_run = 0;
   endtask

   task automatic model_step(input logic [3:0] col_now);
      logic [3:0] cs_old;
      int zeros, ci, ri;
      cs_old = m_cs; m_cs = m_s1; m_s1 = col_now; m_valid = 1'b0;
      case (m_mode)
         0: begin
            ri = (m_scan_t / SC) % 4;
            zeros = 0; ci = 0;
            for (int c = 0; c < 4; c++) if (!cs_old[c]) begin zeros++; ci = c; end
            if ((m_scan_t % SC) == SC-1 && zeros == 1) begin
               m_mode = 1; m_cap = cs_old; m_code = kmap[ri*4+ci]; m_run = 0;
            end else m_scan_t++;
         end
         1: if (cs_old == m_cap) begin
               m_run++;
               if (m_run == DB) begin m_digit = m_code; m_valid = 1'b1; m_held = 1'b1; m_mode = 2; end
            end else begin m_mode = 0; m_scan_t = 0; end
         2: if (cs_old == 4'hF) begin m_mode = 3; m_run = 0; end
         default: if (cs_old == 4'hF) begin
               m_run++;
               if (m_run == DB) begin m_held = 1'b0; m_mode = 0; m_scan_t = 0; end
            end else m_mode = 2;
      endcase
      if (m_mode == 0) begin
         m_row = 4'hF;
         m_row[(m_scan_t / SC) % 4] = 1'b0;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) model_reset();
         else model_step(kif.col);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         chk("row", kif.row, m_row);
         chk("digit", kif.digit, m_digit);
         chk("digit_valid", kif.digit_valid, m_valid);
         chk("key_held", kif.key_held, m_held);
         chk("no_back_to_back", kif.digit_valid & prev_valid, 0);
         prev_valid = kif.digit_valid;
         if (kif.digit_valid === 1'b1) pulses++;
      end
   end

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_pulse(input int maxc, output int lat, output logic [3:0] d);
      lat = -1; d = 4'hX;
      for (int k = 1; k <= maxc; k++) begin
         @(negedge clk);
         if (kif.digit_valid === 1'b1) begin lat = k; d = kif.digit; break; end
      end
      #1;
   endtask

   task automatic pulse_key(input int idx, input string nm, input logic [3:0] exp_d);
      int lat; logic [3:0] d;
      keys[idx] = 1'b1;
      wait_pulse(40, lat, d);
      chk({nm, "_seen"}, lat > 0, 1);
      chk({nm, "_digit"}, d, exp_d);
      settle(5);
      keys[idx] = 1'b0;
      settle(20);
   endtask

   initial begin
      int p0, lat, waited;
      logic [3:0] d;
      settle(3);
      chk("rst_row", kif.row, 4'b1110);
      chk("rst_digit", kif.digit, 4'h0);
      chk("rst_held", kif.key_held, 0);
      #1 reset = 1'b1;

      // Idle scan: row 0 already spent its first dwell cycle under reset release.
      for (int k = 0; k < 32; k++) begin
         logic [3:0] er;
         @(negedge clk); #1;
         er = 4'hF; er[((k + 1) / 4) % 4] = 1'b0;
         chk("idle_row", kif.row, er);
      end
      chk("idle_no_pulse", pulses, 0);

      // '8' clean press
      p0 = pulses;
      keys[9] = 1'b1;
      wait_pulse(40, lat, d);
      chk("p8_latency_ok", (lat >= 1 && lat <= 23), 1);
      chk("p8_digit", d, 4'h8);
      settle(10);
      chk("p8_held", kif.key_held, 1);
      keys[9] = 1'b0;
      settle(DB + 6);
      chk("p8_released", kif.key_held, 0);
      chk("p8_one_pulse", pulses - p0, 1);

      // 'A' with bounce on press and on release
      p0 = pulses;
      for (int b = 0; b < 4; b++) begin keys[3] = ~b[0]; settle(2); end
      keys[3] = 1'b1;
      wait_pulse(40, lat, d);
      chk("pA_digit", d, 4'hA);
      settle(8);
      for (int b = 0; b < 4; b++) begin keys[3] = b[0]; settle(2); end
      keys[3] = 1'b0;
      settle(20);
      chk("pA_one_pulse", pulses - p0, 1);
      chk("pA_released", kif.key_held, 0);

      // '1' and '5' sit on different rows, so row 0 sees a single clean key
      keys[0] = 1'b1; keys[5] = 1'b1;
      settle(60);
      keys = '0;
      settle(20);

      // '5' and '6' share row 1: two low columns are ignored
      p0 = pulses;
      keys[5] = 1'b1; keys[6] = 1'b1;
      settle(60);
      chk("p56_no_pulse", pulses - p0, 0);
      keys = '0;
      settle(20);

      // '0' interrupted by reset two matches into debounce
      p0 = pulses;
      keys[13] = 1'b1;
      waited = 0;
      while (!(m_mode == 1 && m_run == 2) && waited < 40) begin @(negedge clk); waited++; end
      chk("p0_reached_debounce", waited < 40, 1);
      #2 reset = 1'b0;
      #1;
      chk("p0_rst_row", kif.row, 4'b1110);
      chk("p0_rst_digit", kif.digit, 4'h0);
      chk("p0_rst_valid", kif.digit_valid, 0);
      chk("p0_rst_held", kif.key_held, 0);
      settle(2);
      chk("p0_no_pulse_in_reset", pulses - p0, 0);
      #1 reset = 1'b1;
      wait_pulse(40, lat, d);
      chk("p0_after_rst_seen", lat > 0, 1);
      chk("p0_after_rst_digit", d, 4'h0);
      keys[13] = 1'b0;
      settle(20);
      chk("p0_one_pulse", pulses - p0, 1);

      // Code entry 1,0,1,1
      p0 = pulses;
      pulse_key(0,  "seq1a", 4'h1);
      pulse_key(13, "seq0",  4'h0);
      pulse_key(0,  "seq1b", 4'h1);
      pulse_key(0,  "seq1c", 4'h1);
      chk("seq_pulses", pulses - p0, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
